// File: rtl/decoder_n_reg_if.sv
// Select/handshake and decoded-output bundle for decoder_n_reg.
// The controller drives the master side; the decoder sits on the slave side.
interface decoder_n_reg_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 2**SEL_W;

    logic [1:0]         mode;
    logic [SEL_W-1:0]   sel_in;
    logic               in_valid;
    logic               in_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   out_idx;
    logic               out_valid;

    modport master (
        output mode, sel_in, in_valid, dwell,
        input  in_ready, out, out_idx, out_valid
    );

    modport slave (
        input  mode, sel_in, in_valid, dwell,
        output in_ready, out, out_idx, out_valid
    );
endinterface

// File: rtl/decoder_n_reg.sv
// Registered N-to-2^N decoder with one-hot, thermometer and autonomous scan modes.
//   state  | meaning
//   IDLE   | after reset or leaving scan/reserved; out holds its last value
//   STATIC | one-hot/thermometer; each accept re-encodes out
//   SCAN   | walks a one-hot index, one step every dwell+1 cycles
module decoder_n_reg #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    decoder_n_reg_if.slave   bus
);
    localparam int OUT_W = 2**SEL_W;

    localparam logic [1:0] MODE_SCAN = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATIC = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic               accept;
    logic [SEL_W-1:0]   idx_inc;
    logic [OUT_W-1:0]   onehot_sel;
    logic [OUT_W-1:0]   therm_sel;
    logic [OUT_W-1:0]   onehot_inc;

    assign bus.in_ready = ~bus.mode[1];
    assign accept       = bus.in_valid & bus.in_ready;
    assign idx_inc      = idx_q + SEL_W'(1);

    // Bitwise compare keeps every encoding exactly OUT_W wide, including index OUT_W-1.
    always_comb begin
        onehot_sel = '0;
        therm_sel  = '0;
        onehot_inc = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot_sel[i] = (i == int'(bus.sel_in));
            therm_sel[i]  = (i <= int'(bus.sel_in));
            onehot_inc[i] = (i == int'(idx_inc));
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        vld_d   = 1'b0;
        cnt_d   = '0;
        case (state_q)
            IDLE, STATIC: begin
                if (bus.mode == MODE_SCAN) begin
                    state_d = SCAN;
                    out_d   = onehot_sel;
                    idx_d   = bus.sel_in;
                    vld_d   = 1'b1;
                end else if (accept) begin
                    state_d = STATIC;
                    out_d   = bus.mode[0] ? therm_sel : onehot_sel;
                    idx_d   = bus.sel_in;
                    vld_d   = 1'b1;
                end else if (bus.mode == MODE_RSVD) begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (bus.mode != MODE_SCAN) begin
                    state_d = IDLE;
                end else if (cnt_q == bus.dwell) begin
                    out_d = onehot_inc;
                    idx_d = idx_inc;
                    vld_d = 1'b1;
                end else begin
                    // dwell is live: if lowered below cnt_q, the counter rolls over first.
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            out_q   <= OUT_W'(1);
            idx_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_decoder_n_reg.sv
// Directed bench for decoder_n_reg: an 8-output instance plus a 16-output instance.
module tb_decoder_n_reg;
    logic sys_clk;
    logic sys_rst_n;
    int   errors;
    int   checks;

    decoder_n_reg_if #(.SEL_W(3), .DWELL_W(8)) b3 ();
    decoder_n_reg_if #(.SEL_W(4), .DWELL_W(8)) b4 ();

    decoder_n_reg #(.SEL_W(3), .DWELL_W(8)) u_dut3 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (b3)
    );

    decoder_n_reg #(.SEL_W(4), .DWELL_W(8)) u_dut4 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (b4)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n   = 1'b0;
        b3.mode     = 2'b00;
        b3.sel_in   = '0;
        b3.in_valid = 1'b0;
        b3.dwell    = '0;
        b4.mode     = 2'b00;
        b4.sel_in   = '0;
        b4.in_valid = 1'b0;
        b4.dwell    = '0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if (b3.out !== 8'h01) begin
            errors++;
            $display("FAIL reset_out got=%h want=01", b3.out);
        end
        checks++;
        if (b3.out_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_idx got=%0d want=0", b3.out_idx);
        end
        checks++;
        if (b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b want=0", b3.out_valid);
        end
        checks++;
        if (b3.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", b3.in_ready);
        end
        tick();
        checks++;
        if (b3.out !== 8'h01 || b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got out=%h vld=%b want out=01 vld=0", b3.out, b3.out_valid);
        end
    endtask

    task automatic test_onehot_sweep();
        logic [7:0] exp_oh [8];
        exp_oh = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        b3.mode     = 2'b00;
        b3.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b3.sel_in = 3'(i);
            tick();
            checks++;
            if (b3.out !== exp_oh[i] || b3.out_idx !== 3'(i) || b3.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL onehot_%0d got out=%h idx=%0d vld=%b want out=%h idx=%0d vld=1",
                         i, b3.out, b3.out_idx, b3.out_valid, exp_oh[i], i);
            end
        end
        b3.in_valid = 1'b0;
        tick();
        checks++;
        if (b3.out !== 8'h80 || b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL onehot_hold got out=%h vld=%b want out=80 vld=0", b3.out, b3.out_valid);
        end
    endtask

    task automatic test_thermo();
        logic [2:0] sels [3];
        logic [7:0] exps [3];
        sels = '{3'd3, 3'd7, 3'd0};
        exps = '{8'h0F, 8'hFF, 8'h01};
        // Mode change alone must not re-encode the held one-hot value.
        b3.mode = 2'b01;
        tick();
        checks++;
        if (b3.out !== 8'h80 || b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mode_change_hold got out=%h vld=%b want out=80 vld=0", b3.out, b3.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            b3.sel_in   = sels[i];
            b3.in_valid = 1'b1;
            tick();
            b3.in_valid = 1'b0;
            checks++;
            if (b3.out !== exps[i] || b3.out_idx !== sels[i] || b3.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL thermo_%0d got out=%h idx=%0d vld=%b want out=%h idx=%0d vld=1",
                         sels[i], b3.out, b3.out_idx, b3.out_valid, exps[i], sels[i]);
            end
            tick();
            checks++;
            if (b3.out !== exps[i] || b3.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL thermo_hold_%0d got out=%h vld=%b want out=%h vld=0",
                         sels[i], b3.out, b3.out_valid, exps[i]);
            end
        end
    endtask

    task automatic test_scan_wrap();
        logic [7:0] exp_out [6];
        logic       exp_vld [6];
        exp_out = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};
        exp_vld = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        b3.mode     = 2'b10;
        b3.sel_in   = 3'd6;
        b3.dwell    = 8'd2;
        b3.in_valid = 1'b1;
        #1;
        checks++;
        if (b3.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL scan_ready got=%b want=0", b3.in_ready);
        end
        tick();
        checks++;
        if (b3.out !== 8'h40 || b3.out_idx !== 3'd6 || b3.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL scan_entry got out=%h idx=%0d vld=%b want out=40 idx=6 vld=1",
                     b3.out, b3.out_idx, b3.out_valid);
        end
        b3.sel_in = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (b3.out !== exp_out[i] || b3.out_valid !== exp_vld[i] || b3.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL scan_step_%0d got out=%h vld=%b rdy=%b want out=%h vld=%b rdy=0",
                         i, b3.out, b3.out_valid, b3.in_ready, exp_out[i], exp_vld[i]);
            end
        end
        b3.in_valid = 1'b0;
    endtask

    task automatic test_scan_abort_reset();
        logic [7:0] exp_walk [3];
        exp_walk = '{8'h02, 8'h04, 8'h08};
        b3.mode = 2'b11;
        tick();
        checks++;
        if (b3.out !== 8'h01 || b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_exit got out=%h vld=%b want out=01 vld=0", b3.out, b3.out_valid);
        end
        b3.mode   = 2'b10;
        b3.sel_in = 3'd1;
        b3.dwell  = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (b3.out !== exp_walk[i] || b3.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL dwell0_%0d got out=%h vld=%b want out=%h vld=1",
                         i, b3.out, b3.out_valid, exp_walk[i]);
            end
        end
        b3.mode     = 2'b11;
        b3.in_valid = 1'b1;
        b3.sel_in   = 3'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (b3.out !== 8'h08 || b3.out_idx !== 3'd3 || b3.out_valid !== 1'b0 || b3.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL rsvd_hold_%0d got out=%h idx=%0d vld=%b rdy=%b want out=08 idx=3 vld=0 rdy=0",
                         i, b3.out, b3.out_idx, b3.out_valid, b3.in_ready);
            end
        end
        b3.in_valid = 1'b0;
        b3.mode     = 2'b10;
        tick();
        tick();
        checks++;
        if (b3.out !== 8'h40) begin
            errors++;
            $display("FAIL rescan got out=%h want=40", b3.out);
        end
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        b3.mode   = 2'b00;
        checks++;
        if (b3.out !== 8'h01 || b3.out_idx !== 3'd0 || b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_scan_reset got out=%h idx=%0d vld=%b want out=01 idx=0 vld=0",
                     b3.out, b3.out_idx, b3.out_valid);
        end
        tick();
        tick();
        checks++;
        if (b3.out !== 8'h01 || b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got out=%h vld=%b want out=01 vld=0", b3.out, b3.out_valid);
        end
    endtask

    task automatic test_sel_w4();
        b4.mode     = 2'b00;
        b4.sel_in   = 4'd15;
        b4.in_valid = 1'b1;
        tick();
        checks++;
        if (b4.out !== 16'h8000 || b4.out_idx !== 4'd15) begin
            errors++;
            $display("FAIL w4_onehot got out=%h idx=%0d want out=8000 idx=15", b4.out, b4.out_idx);
        end
        b4.mode = 2'b01;
        tick();
        checks++;
        if (b4.out !== 16'hFFFF) begin
            errors++;
            $display("FAIL w4_thermo15 got out=%h want=ffff", b4.out);
        end
        b4.sel_in = 4'd4;
        tick();
        b4.in_valid = 1'b0;
        checks++;
        if (b4.out !== 16'h001F || b4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL w4_thermo4 got out=%h vld=%b want out=001f vld=1", b4.out, b4.out_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_onehot_sweep();
        test_thermo();
        test_scan_wrap();
        test_scan_abort_reset();
        test_sel_w4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
